// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the UART: the core's store path plus the
// select/read-word that the datapath can mux into its load data.
interface mmio_uart_tx_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        sel;
    logic [31:0] rdata;

    modport master (
        output memwrite,
        output dataadr,
        output writedata,
        input  sel,
        input  rdata
    );

    modport slave (
        input  memwrite,
        input  dataadr,
        input  writedata,
        output sel,
        output rdata
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO fed by stores to TXDATA, 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           txd,
    output logic           busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL   = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------- bus decode ----------------
    logic addr_data;
    logic addr_status;
    logic push_req;
    logic ovf_clr;
    logic [31:0] status_word;
    logic unused_bits;

    assign addr_data   = (bus.dataadr == BASE_ADDR);
    assign addr_status = (bus.dataadr == BASE_ADDR + 32'd4);
    assign push_req    = bus.memwrite & addr_data;
    assign ovf_clr     = bus.memwrite & addr_status & bus.writedata[3];
    assign unused_bits = ^bus.writedata[31:8];

    // ---------------- FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_ok;
    logic [7:0]    fifo_head;

    assign fifo_full  = (count_reg == COUNT_FULL);
    assign fifo_empty = (count_reg == '0);
    // A pop frees a slot in the same cycle, so a push to a full FIFO still lands.
    assign push_ok    = push_req & (~fifo_full | pop);
    assign fifo_head  = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= bus.writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_req && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // ---------------- serializer FSM ----------------
    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          txd_reg, txd_next;
    logic          timer_done;

    assign timer_done = (timer_reg == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            txd_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            txd_reg     <= txd_next;
        end
    end

    // txd is registered: each transition computes the level for the state being entered.
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        txd_next     = txd_reg;
        pop          = 1'b0;

        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    state_next = START;
                    timer_next = TIMER_RELOAD;
                    txd_next   = 1'b0;
                end
            end

            START: begin
                if (timer_done) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    timer_next   = TIMER_RELOAD;
                    txd_next     = shift_reg[0];
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end

            DATA: begin
                if (timer_done) begin
                    timer_next = TIMER_RELOAD;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        txd_next   = ^shift_reg;
`else
                        state_next = STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        txd_next     = shift_reg[bit_idx_reg + 3'd1];
                    end
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (timer_done) begin
                    state_next = STOP;
                    timer_next = TIMER_RELOAD;
                    txd_next   = 1'b1;
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end
`endif

            STOP: begin
                if (timer_done) begin
                    timer_next = TIMER_RELOAD;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        state_next = START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                        txd_next   = 1'b1;
                    end
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                timer_next = '0;
                txd_next   = 1'b1;
            end
        endcase
    end

    // ---------------- outputs ----------------
    assign txd  = txd_reg;
    assign busy = (state_reg != IDLE);

    always_comb begin
        status_word       = '0;
        status_word[0]    = fifo_full;
        status_word[1]    = fifo_empty;
        status_word[2]    = busy;
        status_word[3]    = overflow_reg;
        status_word[11:8] = 4'(count_reg);
    end

    assign bus.sel   = addr_data | addr_status;
    assign bus.rdata = addr_status ? status_word : 32'd0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model checked every cycle, plus literal pins.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] STAT = 32'hFFFF_0004;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic txd;
    logic busy;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave),
        .txd  (txd),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    bit         m_active = 0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf = 0;
    bit         m_valid = 0;

    function automatic logic exp_txd();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_t / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int n;
        n = mq.size();
        s = 32'd0;
        s[0] = (n == DEPTH);
        s[1] = (n == 0);
        s[2] = m_active;
        s[3] = m_ovf;
        s[11:8] = 4'(n);
        return s;
    endfunction

    always @(posedge clk) begin
        int  pre;
        bit  do_pop;
        if (!reset) begin
            mq.delete();
            m_active = 0;
            m_t      = 0;
            m_ovf    = 0;
            m_valid  = 1;
        end else if (m_valid) begin
            pre    = mq.size();
            do_pop = 0;
            if (!m_active) begin
                if (pre > 0) do_pop = 1;
            end else if (m_t == FRAME - 1) begin
                if (pre > 0) do_pop = 1;
                else m_active = 0;
            end else begin
                m_t++;
            end
            if (do_pop) begin
                m_byte   = mq.pop_front();
                m_active = 1;
                m_t      = 0;
            end
            if (bus.memwrite && bus.dataadr == BASE) begin
                if (pre < DEPTH || do_pop) mq.push_back(bus.writedata[7:0]);
                else m_ovf = 1;
            end
            if (bus.memwrite && bus.dataadr == STAT && bus.writedata[3]) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("txd", {31'd0, txd}, {31'd0, exp_txd()});
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("sel", {31'd0, bus.sel},
                {31'd0, (bus.dataadr == BASE) || (bus.dataadr == STAT)});
            chk("rdata", bus.rdata, (bus.dataadr == STAT) ? exp_status() : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite  = 1'b1;
        bus.dataadr   = a;
        bus.writedata = d;
        tick();
        bus.memwrite  = 1'b0;
        bus.dataadr   = STAT;
        bus.writedata = 32'd0;
    endtask

    task automatic wait_idle(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (!m_active && mq.size() == 0) break;
            tick();
        end
        if (i == limit) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_and_capture(input logic [7:0] b, input string tag,
                                    input int exp_bits[NBITS]);
        logic samp_txd[50];
        int   nbusy;
        wr(BASE, {24'h0000_00, b});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            samp_txd[i] = txd;
            nbusy += int'(busy);
        end
        chk({tag, "_idle_before_start"}, {31'd0, samp_txd[0]}, 32'd1);
        for (int bi = 0; bi < NBITS; bi++) begin
            chk({tag, "_bit"}, {31'd0, samp_txd[2 + 4*bi]}, exp_bits[bi]);
        end
        chk({tag, "_busy_cycles"}, nbusy, FRAME);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int a5_exp[NBITS];
        int p07_exp[NBITS];
        int i;
        int nbusy;

`ifdef UART_TX_PARITY_EN
        a5_exp  = '{0, 1,0,1,0,0,1,0,1, 0, 1};
        p07_exp = '{0, 1,1,1,0,0,0,0,0, 1, 1};
`else
        a5_exp  = '{0, 1,0,1,0,0,1,0,1, 1};
        p07_exp = '{0, 1,1,1,0,0,0,0,0, 1};
`endif
        bus.memwrite  = 1'b0;
        bus.dataadr   = STAT;
        bus.writedata = 32'd0;

        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        chk("reset_status", bus.rdata, 32'h0000_0002);
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        tick();

        // Single byte 0xA5.
        send_and_capture(8'hA5, "a5", a5_exp);
        $display("txn: sent 0xA5, checks so far %0d", n_checks);
        wait_idle(200);

        // Parity-bearing byte 0x07 (parity bit 1 when enabled).
        send_and_capture(8'h07, "b07", p07_exp);
        $display("txn: sent 0x07, checks so far %0d", n_checks);
        wait_idle(200);

        // Overflow: one byte on the line, then nine stores.
        wr(BASE, 32'h0000_0011);
        for (i = 0; i < 9; i++) wr(BASE, 32'hFFFF_FF20 + i);
        @(negedge clk);
        chk("overflow_status", bus.rdata, 32'h0000_080D);
        $display("txn: nine stores while busy, status %h", bus.rdata);
        tick();

        // Clear overflow, refill to full, then push exactly as a stop bit ends.
        wr(STAT, 32'h0000_0008);
        for (i = 0; i < 400 && mq.size() != 7; i++) tick();
        if (i == 400) chk("wait_size7_timeout", 32'd1, 32'd0);
        wr(BASE, 32'h0000_0030);
        for (i = 0; i < 400; i++) begin
            if (m_active && m_t == FRAME - 1) break;
            tick();
        end
        if (i == 400) chk("wait_stop_end_timeout", 32'd1, 32'd0);
        wr(BASE, 32'h0000_0077);
        @(negedge clk);
        chk("full_push_pop_status", bus.rdata, 32'h0000_0805);
        $display("txn: push on stop end while full, status %h", bus.rdata);
        tick();
        wait_idle(3000);
        @(negedge clk);
        chk("drained_status", bus.rdata, 32'h0000_0002);
        tick();

        // Three queued bytes: one continuous busy run.
        wr(BASE, 32'h0000_0031);
        wr(BASE, 32'h0000_0032);
        wr(BASE, 32'h0000_0033);
        nbusy = 0;
        for (i = 0; i < 3 * FRAME + 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        chk("three_frames_busy", nbusy, 3 * FRAME - 1);
        chk("three_frames_status", bus.rdata, 32'h0000_0002);
        $display("txn: three back-to-back frames, busy cycles %0d", nbusy);
        tick();

        // Reset in the middle of a data bit.
        wr(BASE, 32'h0000_00C3);
        repeat (10) tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("midreset_txd", {31'd0, txd}, 32'd1);
        chk("midreset_status", bus.rdata, 32'h0000_0002);
        tick();
        reset = 1'b1;
        tick();
        send_and_capture(8'hA5, "after_reset", a5_exp);
        $display("txn: reset mid-frame then resend 0xA5");
        wait_idle(200);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
